// File: rtl/complex_frame_acc_pkg.sv
// Package: complex_frame_acc_pkg
// Shared widths and types for the complex multiplier datapath and the frame
// accumulator that follows it.
//   PROD_W      width of one signed product component from the multiplier
//   DEF_LEN     default number of products summed per frame
//   acc_w_min() smallest accumulator width that cannot overflow over a frame
//   out_state_e result holding register state (EMPTY / FULL)
package complex_frame_acc_pkg;

  localparam int PROD_W  = 16;
  localparam int DEF_LEN = 4;

  // Summing len values of in_w bits needs clog2(len) extra bits of headroom.
  function automatic int acc_w_min(input int in_w, input int len);
    return in_w + $clog2(len);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/complex_acc_lane.sv
// Module: complex_acc_lane
// One signed accumulator lane (used once for real, once for imaginary).
//   clk, rst  clock and synchronous active-high reset
//   clear     drop the partial sum; a sample added this cycle starts fresh
//   add       din is a valid sample this cycle
//   finish    this sample closes the frame; sum is the frame result
//   din       signed sample, IN_W bits
//   sum       signed running total including din (the frame result on finish)
module complex_acc_lane #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             add,
  input  logic             finish,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] sum
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] ext;

  // Size cast of a signed operand sign-extends to the accumulator width.
  assign ext  = ACC_W'($signed(din));
  // A clear in the same cycle as a sample makes that sample the first term.
  assign base = clear ? '0 : acc;
  assign sum  = base + ext;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (finish) begin
      acc <= '0;
    end else if (add) begin
      acc <= sum;
    end else if (clear) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/complex_frame_acc.sv
// Module: complex_frame_acc
// Sums LEN consecutive valid complex products into one full-precision result
// (a complex dot product over a frame) and holds it for a valid/ready consumer.
// Upstream cannot be stalled, so an unconsumed result is overwritten and the
// sticky overrun flag records it.
//   clk, rst              clock and synchronous active-high reset
//   in_valid, in_real/imag  product input, IN_W bits signed
//   frame_start           restart the frame (same-cycle sample becomes sample 0)
//   out_valid, out_ready  result handshake
//   out_real/imag         frame sum, ACC_W bits signed
//   sample_cnt            samples accepted in the current frame
//   overrun               sticky: a pending result was overwritten
module complex_frame_acc
  import complex_frame_acc_pkg::*;
#(
  parameter int IN_W  = PROD_W,
  parameter int LEN   = DEF_LEN,
  parameter int ACC_W = acc_w_min(PROD_W, DEF_LEN),
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_real,
  input  logic [IN_W-1:0]  in_imag,
  input  logic             frame_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_real,
  output logic [ACC_W-1:0] out_imag,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

  logic [CNT_W-1:0] cnt_base;
  logic             frame_done;
  logic [ACC_W-1:0] sum_real;
  logic [ACC_W-1:0] sum_imag;
  out_state_e       state;

  // frame_start restarts the count before the current sample is considered,
  // so with LEN=1 a sample arriving alongside frame_start completes a frame.
  assign cnt_base   = frame_start ? '0 : sample_cnt;
  assign frame_done = in_valid && (cnt_base == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
    end else if (in_valid) begin
      sample_cnt <= frame_done ? '0 : cnt_base + 1'b1;
    end else begin
      sample_cnt <= cnt_base;
    end
  end

  complex_acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane_real (
    .clk    (clk),
    .rst    (rst),
    .clear  (frame_start),
    .add    (in_valid),
    .finish (frame_done),
    .din    (in_real),
    .sum    (sum_real)
  );

  complex_acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane_imag (
    .clk    (clk),
    .rst    (rst),
    .clear  (frame_start),
    .add    (in_valid),
    .finish (frame_done),
    .din    (in_imag),
    .sum    (sum_imag)
  );

  // Result register and its EMPTY/FULL handshake. A completing frame always
  // wins over a consume; overrun marks only an overwrite nobody accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_real <= '0;
      out_imag <= '0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (frame_done) begin
            state    <= FULL;
            out_real <= sum_real;
            out_imag <= sum_imag;
          end
        end
        FULL: begin
          if (frame_done) begin
            out_real <= sum_real;
            out_imag <= sum_imag;
            if (!out_ready) overrun <= 1'b1;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_complex_frame_acc.sv
// Testbench: tb_complex_frame_acc
// Directed scenarios for the frame accumulator plus a randomized run, all
// checked against a behavioural model holding the current frame as a queue.
module tb_complex_frame_acc;

  localparam int IN_W  = 16;
  localparam int LEN   = 4;
  localparam int ACC_W = 18;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [IN_W-1:0]  in_real;
  logic [IN_W-1:0]  in_imag;
  logic             frame_start;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_real;
  logic [ACC_W-1:0] out_imag;
  logic [CNT_W-1:0] sample_cnt;
  logic             overrun;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: samples of the open frame, and the held result.
  int   q_re[$];
  int   q_im[$];
  logic m_valid = 1'b0;
  int   m_re    = 0;
  int   m_im    = 0;
  logic m_ovr   = 1'b0;

  always #5 clk = ~clk;

  complex_frame_acc #(
    .IN_W(IN_W), .LEN(LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_real     (in_real),
    .in_imag     (in_imag),
    .frame_start (frame_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_real    (out_real),
    .out_imag    (out_imag),
    .sample_cnt  (sample_cnt),
    .overrun     (overrun)
  );

  // Drives one clock cycle of inputs, advances the model across the edge and
  // returns #1 after the edge, when outputs are settled for comparison.
  task automatic cyc(input logic v, input int re, input int im,
                     input logic fs, input logic rdy, input logic r = 1'b0);
    int  s_re, s_im;
    bit  done;
    rst         = r;
    in_valid    = v;
    in_real     = IN_W'(re);
    in_imag     = IN_W'(im);
    frame_start = fs;
    out_ready   = rdy;
    @(posedge clk);
    if (r) begin
      q_re.delete(); q_im.delete();
      m_valid = 1'b0; m_re = 0; m_im = 0; m_ovr = 1'b0;
    end else begin
      done = 1'b0;
      if (fs) begin q_re.delete(); q_im.delete(); end
      if (v) begin
        q_re.push_back(int'($signed(in_real)));
        q_im.push_back(int'($signed(in_imag)));
        if (q_re.size() == LEN) begin
          s_re = 0; s_im = 0;
          foreach (q_re[i]) begin s_re += q_re[i]; s_im += q_im[i]; end
          q_re.delete(); q_im.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (m_valid && !rdy) m_ovr = 1'b1;
        m_valid = 1'b1; m_re = s_re; m_im = s_im;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  function automatic int sre(input logic [ACC_W-1:0] x);
    return int'($signed(x));
  endfunction

  task automatic test_reset();
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b0 || sample_cnt !== '0 || overrun !== 1'b0 ||
        out_real !== '0 || out_imag !== '0) begin
      miscompares++;
      $display("FAIL reset: valid=%b cnt=%0d ovr=%b out=(%0d,%0d) want 0,0,0,(0,0)",
               out_valid, sample_cnt, overrun, sre(out_real), sre(out_imag));
    end
  endtask

  task automatic test_spaced_frame();
    int re[4] = '{-5, -20, -16, -3};
    int im[4] = '{10, 40, 22, 4};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, re[i], im[i], 1'b0, 1'b1);
      if (i < 3) begin
        vectors++;
        if (out_valid !== 1'b0 || sample_cnt !== CNT_W'(i + 1)) begin
          miscompares++;
          $display("FAIL spaced_partial[%0d]: valid=%b cnt=%0d want 0,%0d",
                   i, out_valid, sample_cnt, i + 1);
        end
        cyc(1'b0, 0, 0, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 1'b0, 1'b1);
      end
    end
    vectors++;
    if (out_valid !== 1'b1 || sre(out_real) !== -44 || sre(out_imag) !== 76) begin
      miscompares++;
      $display("FAIL spaced_result: valid=%b out=(%0d,%0d) want 1,(-44,76)",
               out_valid, sre(out_real), sre(out_imag));
    end
    cyc(1'b0, 0, 0, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL spaced_consume: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 4; i++) cyc(1'b1, -32768, 32767, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || sre(out_real) !== -131072 || sre(out_imag) !== 131068) begin
      miscompares++;
      $display("FAIL extremes: valid=%b out=(%0d,%0d) want 1,(-131072,131068)",
               out_valid, sre(out_real), sre(out_imag));
    end
    cyc(1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1, 1, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || sre(out_real) !== 4 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_first: valid=%b re=%0d ovr=%b want 1,4,0",
               out_valid, sre(out_real), overrun);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 2, -2, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || sre(out_real) !== 8 || sre(out_imag) !== -8 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_second: valid=%b out=(%0d,%0d) ovr=%b want 1,(8,-8),1",
               out_valid, sre(out_real), sre(out_imag), overrun);
    end
    cyc(1'b0, 0, 0, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_drain: valid=%b ovr=%b want 0,1", out_valid, overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 3; i++) cyc(1'b1, 7, 7, 1'b0, 1'b1);
    cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (overrun !== 1'b0 || sample_cnt !== '0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: ovr=%b cnt=%0d valid=%b want 0,0,0",
               overrun, sample_cnt, out_valid);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 1, 1, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || sre(out_real) !== 4 || sre(out_imag) !== 4) begin
      miscompares++;
      $display("FAIL rst_mid_result: valid=%b out=(%0d,%0d) want 1,(4,4)",
               out_valid, sre(out_real), sre(out_imag));
    end
    cyc(1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_frame_start();
    cyc(1'b1, 100, 100, 1'b0, 1'b1);
    cyc(1'b1, 100, 100, 1'b0, 1'b1);
    cyc(1'b1, 1, 0, 1'b1, 1'b1);
    vectors++;
    if (sample_cnt !== CNT_W'(1) || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fs_restart: cnt=%0d valid=%b want 1,0", sample_cnt, out_valid);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1, 0, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || sre(out_real) !== 4 || sre(out_imag) !== 0) begin
      miscompares++;
      $display("FAIL fs_result: valid=%b out=(%0d,%0d) want 1,(4,0)",
               out_valid, sre(out_real), sre(out_imag));
    end
    cyc(1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back_consume();
    for (int i = 0; i < 4; i++) cyc(1'b1, 3, 3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 5, -5, 1'b0, (i == 3));
    vectors++;
    if (out_valid !== 1'b1 || sre(out_real) !== 20 || sre(out_imag) !== -20 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_consume: valid=%b out=(%0d,%0d) ovr=%b want 1,(20,-20),0",
               out_valid, sre(out_real), sre(out_imag), overrun);
    end
    cyc(1'b0, 0, 0, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 9) < 7),
          int'($urandom_range(0, 65535)) - 32768,
          int'($urandom_range(0, 65535)) - 32768,
          ($urandom_range(0, 19) == 0),
          $urandom_range(0, 1),
          ($urandom_range(0, 99) == 0));
      vectors++;
      if (out_valid !== m_valid || sample_cnt !== CNT_W'(q_re.size()) ||
          overrun !== m_ovr || (m_valid && (sre(out_real) !== m_re || sre(out_imag) !== m_im))) begin
        miscompares++;
        $display("FAIL random[%0d]: valid=%b cnt=%0d ovr=%b out=(%0d,%0d) want %b,%0d,%b,(%0d,%0d)",
                 n, out_valid, sample_cnt, overrun, sre(out_real), sre(out_imag),
                 m_valid, q_re.size(), m_ovr, m_re, m_im);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0;
    frame_start = 1'b0; out_ready = 1'b0;
    test_reset();
    test_spaced_frame();
    test_extremes();
    test_overrun();
    test_reset_mid_frame();
    test_frame_start();
    test_back_to_back_consume();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
